// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and counter width.
// Imported by pipe_ctrl and pipe_perf_cnt.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_ST_RUN   = 2'd0,
    PC_ST_MWAIT = 2'd1,
    PC_ST_DRAIN = 2'd2,
    PC_ST_ERR   = 2'd3
  } pc_state_e;

  localparam int PC_PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running event counter with synchronous clear and count enable.
// One cycle from enable to count update; wraps modulo 2^W.
module pipe_perf_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int W = PC_PERF_CNT_W
) (
  input  logic         clk_i,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk_i) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard/sequencing controller: stall/bubble pairs, zero latency from inputs.
// Optional performance counters built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic [4:0]  D_rs1_i,
  input  logic [4:0]  D_rs2_i,
  input  logic        D_use_rs1_i,
  input  logic        D_use_rs2_i,
  input  logic        D_fence_i,
  input  logic [4:0]  E_dstE_i,
  input  logic        E_need_dstE_i,
  input  logic        E_is_load_i,
  input  logic        E_redirect_i,
  input  logic        E_valid_i,
  input  logic        M_valid_i,
  input  logic        W_valid_i,
  input  logic        M_req_i,
  input  logic        M_ready_i,
  output logic        F_stall_o,
  output logic        F_bubble_o,
  output logic        D_stall_o,
  output logic        D_bubble_o,
  output logic        E_stall_o,
  output logic        E_bubble_o,
  output logic        M_stall_o,
  output logic        M_bubble_o,
  output logic        timeout_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] mwait_cnt_o
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  pc_state_e         state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic mem_wait, load_use, drain, in_err;

  assign mem_wait = M_req_i & ~M_ready_i;
  assign load_use = E_is_load_i & E_need_dstE_i & (E_dstE_i != 5'd0) &
                    ((D_use_rs1_i & (D_rs1_i == E_dstE_i)) |
                     (D_use_rs2_i & (D_rs2_i == E_dstE_i)));
  assign drain    = D_fence_i & (E_valid_i | M_valid_i | W_valid_i);
  assign in_err   = (state_q == PC_ST_ERR);
  assign timeout_o = in_err;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q    <= PC_ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    F_stall_o  = 1'b0;
    F_bubble_o = 1'b0;
    D_stall_o  = 1'b0;
    D_bubble_o = 1'b0;
    E_stall_o  = 1'b0;
    E_bubble_o = 1'b0;
    M_stall_o  = 1'b0;
    M_bubble_o = 1'b0;

    if (rst) begin
      F_bubble_o = 1'b1;
      D_bubble_o = 1'b1;
      E_bubble_o = 1'b1;
      M_bubble_o = 1'b1;
    end else if (in_err) begin
      F_stall_o = 1'b1;
      D_stall_o = 1'b1;
      E_stall_o = 1'b1;
      M_stall_o = 1'b1;
    end else if (mem_wait) begin
      F_stall_o  = 1'b1;
      D_stall_o  = 1'b1;
      E_stall_o  = 1'b1;
      M_bubble_o = 1'b1;
    end else if (E_redirect_i) begin
      F_bubble_o = 1'b1;
      D_bubble_o = 1'b1;
    end else if (load_use || drain) begin
      F_stall_o  = 1'b1;
      D_bubble_o = 1'b1;
    end

    unique case (state_q)
      PC_ST_RUN, PC_ST_DRAIN: begin
        if (mem_wait) begin
          state_d    = PC_ST_MWAIT;
          wait_cnt_d = WCNT_W'(1);
        end else if (state_q == PC_ST_RUN) begin
          if (drain && !E_redirect_i) state_d = PC_ST_DRAIN;
        end else if (!drain || E_redirect_i) begin
          state_d = PC_ST_RUN;
        end
      end
      PC_ST_MWAIT: begin
        // A ready in the same cycle as the timeout condition completes normally.
        if (mem_wait) begin
          if (wait_cnt_q == WCNT_LAST) state_d = PC_ST_ERR;
          if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
          state_d = PC_ST_RUN;
        end
      end
      PC_ST_ERR: state_d = PC_ST_ERR;
      default:   state_d = PC_ST_RUN;
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  logic count_ok, stall_en, flush_en, mwait_en;

  assign count_ok = ~rst & ~in_err;
  assign stall_en = count_ok & ~mem_wait & ~E_redirect_i & (load_use | drain);
  assign flush_en = count_ok & ~mem_wait & E_redirect_i;
  assign mwait_en = count_ok & mem_wait;

  pipe_perf_cnt #(.W(PC_PERF_CNT_W)) u_stall_cnt (
    .clk_i (clk_i), .clr (rst), .en (stall_en), .cnt (stall_cnt_o)
  );
  pipe_perf_cnt #(.W(PC_PERF_CNT_W)) u_flush_cnt (
    .clk_i (clk_i), .clr (rst), .en (flush_en), .cnt (flush_cnt_o)
  );
  pipe_perf_cnt #(.W(PC_PERF_CNT_W)) u_mwait_cnt (
    .clk_i (clk_i), .clr (rst), .en (mwait_en), .cnt (mwait_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
  assign mwait_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (MEM_TIMEOUT=4): vector table, corner sequences, random vs model.
module tb_pipe_ctrl;

  localparam int MT = 4;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector order: {F_stall,F_bubble,D_stall,D_bubble,E_stall,E_bubble,M_stall,M_bubble}
  localparam logic [7:0] C_NONE = 8'h00;
  localparam logic [7:0] C_MW   = 8'hA9;
  localparam logic [7:0] C_RED  = 8'h50;
  localparam logic [7:0] C_HOLD = 8'h90;
  localparam logic [7:0] C_ERR  = 8'hAA;
  localparam logic [7:0] C_RST  = 8'h55;

  logic        clk_i = 1'b0;
  logic        rst;
  logic [4:0]  D_rs1_i, D_rs2_i, E_dstE_i;
  logic        D_use_rs1_i, D_use_rs2_i, D_fence_i;
  logic        E_need_dstE_i, E_is_load_i, E_redirect_i;
  logic        E_valid_i, M_valid_i, W_valid_i, M_req_i, M_ready_i;
  logic        F_stall_o, F_bubble_o, D_stall_o, D_bubble_o;
  logic        E_stall_o, E_bubble_o, M_stall_o, M_bubble_o, timeout_o;
  logic [31:0] stall_cnt_o, flush_cnt_o, mwait_cnt_o;

  always #5 clk_i = ~clk_i;

  pipe_ctrl #(.MEM_TIMEOUT(MT)) dut (
    .clk_i(clk_i), .rst(rst),
    .D_rs1_i(D_rs1_i), .D_rs2_i(D_rs2_i),
    .D_use_rs1_i(D_use_rs1_i), .D_use_rs2_i(D_use_rs2_i), .D_fence_i(D_fence_i),
    .E_dstE_i(E_dstE_i), .E_need_dstE_i(E_need_dstE_i), .E_is_load_i(E_is_load_i),
    .E_redirect_i(E_redirect_i),
    .E_valid_i(E_valid_i), .M_valid_i(M_valid_i), .W_valid_i(W_valid_i),
    .M_req_i(M_req_i), .M_ready_i(M_ready_i),
    .F_stall_o(F_stall_o), .F_bubble_o(F_bubble_o),
    .D_stall_o(D_stall_o), .D_bubble_o(D_bubble_o),
    .E_stall_o(E_stall_o), .E_bubble_o(E_bubble_o),
    .M_stall_o(M_stall_o), .M_bubble_o(M_bubble_o),
    .timeout_o(timeout_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .mwait_cnt_o(mwait_cnt_o)
  );

  logic [7:0] ctrl;
  assign ctrl = {F_stall_o, F_bubble_o, D_stall_o, D_bubble_o,
                 E_stall_o, E_bubble_o, M_stall_o, M_bubble_o};

  int total = 0;
  int bad = 0;

  // Reference model: error flag, run length of consecutive memory waits, event tallies.
  bit          m_init = 1'b0;
  bit          m_err;
  int          m_consec;
  logic [31:0] m_stall, m_flush, m_mwait;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_load_use();
    bit hit1, hit2;
    hit1 = D_use_rs1_i && (D_rs1_i == E_dstE_i);
    hit2 = D_use_rs2_i && (D_rs2_i == E_dstE_i);
    return E_is_load_i && E_need_dstE_i && (E_dstE_i != 0) && (hit1 || hit2);
  endfunction

  function automatic bit m_drain();
    return D_fence_i && (E_valid_i || M_valid_i || W_valid_i);
  endfunction

  function automatic bit m_memwait();
    return M_req_i && !M_ready_i;
  endfunction

  function automatic logic [7:0] model_ctrl();
    if (rst) return C_RST;
    if (m_err) return C_ERR;
    if (m_memwait()) return C_MW;
    if (E_redirect_i) return C_RED;
    if (m_load_use() || m_drain()) return C_HOLD;
    return C_NONE;
  endfunction

  task automatic model_update();
    if (rst) begin
      m_init = 1'b1; m_err = 1'b0; m_consec = 0;
      m_stall = 0; m_flush = 0; m_mwait = 0;
    end else if (m_init && !m_err) begin
      if (m_memwait()) begin
        m_mwait++;
        m_consec++;
        if (m_consec >= MT) m_err = 1'b1;
      end else begin
        m_consec = 0;
        if (E_redirect_i) m_flush++;
        else if (m_load_use() || m_drain()) m_stall++;
      end
    end
  endtask

  // Inputs are already driven just after a rising edge; check mid-cycle, then advance.
  task automatic step();
    logic [7:0] e;
    e = model_ctrl();
    @(negedge clk_i);
    chk("ctrl", {24'd0, ctrl}, {24'd0, e});
    if (m_init) begin
      chk("timeout", {31'd0, timeout_o}, {31'd0, m_err});
      chk("stall_cnt", stall_cnt_o, PERF ? m_stall : 32'd0);
      chk("flush_cnt", flush_cnt_o, PERF ? m_flush : 32'd0);
      chk("mwait_cnt", mwait_cnt_o, PERF ? m_mwait : 32'd0);
    end
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    D_rs1_i = 0; D_rs2_i = 0; D_use_rs1_i = 0; D_use_rs2_i = 0; D_fence_i = 0;
    E_dstE_i = 0; E_need_dstE_i = 0; E_is_load_i = 0; E_redirect_i = 0;
    E_valid_i = 0; M_valid_i = 0; W_valid_i = 0; M_req_i = 0; M_ready_i = 0;
  endtask

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2, fence;
    logic [4:0] dst;
    logic       need, load, redir, ev, mv, wv, req, rdy;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[12];
  logic [31:0] base;

  initial begin
    //             rs1   rs2   u1 u2 fen dst  need ld red ev mv wv req rdy exp
    tbl[0]  = '{5'd0, 5'd5, 0, 1, 0, 5'd5, 1, 1, 0, 0, 0, 0, 0, 0, C_HOLD};
    tbl[1]  = '{5'd5, 5'd0, 0, 0, 0, 5'd5, 1, 1, 0, 0, 0, 0, 0, 0, C_NONE};
    tbl[2]  = '{5'd0, 5'd0, 1, 1, 0, 5'd0, 1, 1, 0, 0, 0, 0, 0, 0, C_NONE};
    tbl[3]  = '{5'd7, 5'd7, 1, 1, 0, 5'd7, 1, 0, 0, 0, 0, 0, 0, 0, C_NONE};
    tbl[4]  = '{5'd7, 5'd0, 1, 0, 0, 5'd7, 0, 1, 0, 0, 0, 0, 0, 0, C_NONE};
    tbl[5]  = '{5'd3, 5'd0, 1, 0, 0, 5'd3, 1, 1, 1, 0, 0, 0, 0, 0, C_RED};
    tbl[6]  = '{5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, 0, 1, 0, 0, 0, 0, C_HOLD};
    tbl[7]  = '{5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE};
    tbl[8]  = '{5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, 1, 0, 0, 1, 0, 0, C_RED};
    tbl[9]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, 0, 0, 1, 0, C_MW};
    tbl[10] = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE};
    tbl[11] = '{5'd9, 5'd0, 1, 0, 0, 5'd9, 1, 1, 0, 0, 0, 0, 1, 0, C_MW};

    idle_inputs();
    rst = 1'b1;
    @(posedge clk_i); #1;
    step();
    step();
    rst = 1'b0;
    step();

    // Vector table in RUN.
    for (int i = 0; i < 12; i++) begin
      D_rs1_i = tbl[i].rs1; D_rs2_i = tbl[i].rs2;
      D_use_rs1_i = tbl[i].u1; D_use_rs2_i = tbl[i].u2; D_fence_i = tbl[i].fence;
      E_dstE_i = tbl[i].dst; E_need_dstE_i = tbl[i].need; E_is_load_i = tbl[i].load;
      E_redirect_i = tbl[i].redir;
      E_valid_i = tbl[i].ev; M_valid_i = tbl[i].mv; W_valid_i = tbl[i].wv;
      M_req_i = tbl[i].req; M_ready_i = tbl[i].rdy;
      #2;
      chk($sformatf("vec%0d", i), {24'd0, ctrl}, {24'd0, tbl[i].exp});
      step();
    end
    idle_inputs();
    step();

    // Redirect with load-use: one flush counted.
    base = flush_cnt_o;
    E_is_load_i = 1; E_need_dstE_i = 1; E_dstE_i = 5'd5; D_rs2_i = 5'd5; D_use_rs2_i = 1;
    E_redirect_i = 1;
    step();
    idle_inputs();
    step();
    chk("redir_flush_delta", flush_cnt_o - base, PERF ? 32'd1 : 32'd0);

    // Three not-ready memory cycles, then completion.
    base = mwait_cnt_o;
    M_req_i = 1; M_ready_i = 0;
    repeat (3) step();
    M_ready_i = 1;
    step();
    idle_inputs();
    step();
    chk("mwait_delta", mwait_cnt_o - base, PERF ? 32'd3 : 32'd0);
    chk("mwait_no_timeout", {31'd0, timeout_o}, 32'd0);

    // Ready arriving on the would-be timeout cycle completes normally.
    M_req_i = 1; M_ready_i = 0;
    repeat (MT - 1) step();
    M_ready_i = 1;
    step();
    idle_inputs();
    step();
    chk("ready_at_limit_no_timeout", {31'd0, timeout_o}, 32'd0);

    // Fence draining two older instructions.
    base = stall_cnt_o;
    D_fence_i = 1; E_valid_i = 1; M_valid_i = 1;
    step();
    E_valid_i = 0; M_valid_i = 1; W_valid_i = 1;
    step();
    M_valid_i = 0; W_valid_i = 0;
    #2;
    chk("fence_advances", {24'd0, ctrl}, {24'd0, C_NONE});
    step();
    idle_inputs();
    step();
    chk("fence_stall_delta", stall_cnt_o - base, PERF ? 32'd2 : 32'd0);

    // Watchdog: ready never rises.
    M_req_i = 1; M_ready_i = 0;
    repeat (MT + 2) step();
    chk("watchdog_timeout", {31'd0, timeout_o}, 32'd1);
    chk("watchdog_frozen", {24'd0, ctrl}, {24'd0, C_ERR});
    rst = 1;
    step();
    rst = 0; M_req_i = 0;
    step();
    chk("post_err_timeout", {31'd0, timeout_o}, 32'd0);
    chk("post_err_mwait_cnt", mwait_cnt_o, 32'd0);

    // Reset in the middle of a memory wait.
    M_req_i = 1; M_ready_i = 0;
    repeat (2) step();
    rst = 1;
    #2;
    chk("rst_mid_mwait_bubbles", {24'd0, ctrl}, {24'd0, C_RST});
    step();
    rst = 0;
    repeat (MT - 1) step();
    chk("rst_mid_mwait_restart", {31'd0, timeout_o}, 32'd0);
    idle_inputs();
    step();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 39) == 0);
      D_rs1_i       = 5'($urandom_range(0, 3));
      D_rs2_i       = 5'($urandom_range(0, 3));
      D_use_rs1_i   = 1'($urandom);
      D_use_rs2_i   = 1'($urandom);
      D_fence_i     = ($urandom_range(0, 4) == 0);
      E_dstE_i      = 5'($urandom_range(0, 3));
      E_need_dstE_i = 1'($urandom);
      E_is_load_i   = 1'($urandom);
      E_redirect_i  = ($urandom_range(0, 5) == 0);
      E_valid_i     = 1'($urandom);
      M_valid_i     = 1'($urandom);
      W_valid_i     = 1'($urandom);
      M_req_i       = ($urandom_range(0, 2) == 0);
      M_ready_i     = 1'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
